// File: rtl/counter_pkg.sv
// Shared encodings for the modulus counter: one-shot FSM states, direction and mode values.
package counter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/prescaler_tick.sv
// Clock-enable prescaler: asserts step once every div+1 enabled cycles.
module prescaler_tick #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               step
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign step = en & (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || step) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_mod_nbit.sv
// Programmable-modulus up/down counter with parallel load, prescaled stepping and a
// one-shot mode (start/busy/done) for modulator timing.
module counter_mod_nbit
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up_dn,
  input  logic               mode,
  input  logic               start,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   mod_val,
  input  logic [PRESC_W-1:0] presc_div,
  output logic [WIDTH-1:0]   count,
  output logic               co,
  output logic               wrap,
  output logic               busy,
  output logic               done
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [1:0]       state_q, state_d;

  logic             step;
  logic             start_eff;
  logic             step_wrap;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] init_val;

  assign start_eff = start & (mode == MODE_ONESHOT);

  prescaler_tick #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load | start_eff),
    .div  (presc_div),
    .step (step)
  );

  // Candidate next value for a step; counts above mod_val (after a load) fold back in range.
  always_comb begin
    step_wrap = 1'b0;
    step_val  = count_q;
    term_val  = '0;
    init_val  = '0;
    if (up_dn == DIR_UP) begin
      step_wrap = (count_q >= mod_val);
      step_val  = step_wrap ? '0 : count_q + 1'b1;
      term_val  = mod_val;
      init_val  = '0;
    end else begin
      step_wrap = (count_q == '0) || (count_q > mod_val);
      step_val  = step_wrap ? mod_val : count_q - 1'b1;
      term_val  = '0;
      init_val  = mod_val;
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    state_d = state_q;
    if (load) begin
      count_d = load_val;
    end else if (start_eff) begin
      count_d = init_val;
      state_d = ST_RUN;
    end else if (step) begin
      if (mode == MODE_FREE) begin
        count_d = step_val;
        wrap_d  = step_wrap;
      end else if (state_q == ST_RUN) begin
        if (step_wrap) begin
          count_d = term_val;
          wrap_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          count_d = step_val;
        end
      end
    end
    if (mode == MODE_FREE) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      state_q <= state_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign co    = (up_dn == DIR_UP) ? (count_q == mod_val) : (count_q == '0);

endmodule

// File: tb/tb_counter_mod_nbit.sv
// Directed self-checking bench for counter_mod_nbit (WIDTH=10, PRESC_W=8).
module tb_counter_mod_nbit;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       mode;
  logic       start;
  logic       load;
  logic [9:0] load_val;
  logic [9:0] mod_val;
  logic [7:0] presc_div;
  logic [9:0] count;
  logic       co;
  logic       wrap;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  counter_mod_nbit #(
    .WIDTH   (10),
    .PRESC_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up_dn     (up_dn),
    .mode      (mode),
    .start     (start),
    .load      (load),
    .load_val  (load_val),
    .mod_val   (mod_val),
    .presc_div (presc_div),
    .count     (count),
    .co        (co),
    .wrap      (wrap),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int c, input bit w, input bit b, input bit d);
    check_eq({tag, ".count"}, 32'(count), 32'(c));
    check_eq({tag, ".wrap"},  32'(wrap),  32'(w));
    check_eq({tag, ".busy"},  32'(busy),  32'(b));
    check_eq({tag, ".done"},  32'(done),  32'(d));
  endtask

  initial begin
    int s;
    int exp_c;
    rst = 1'b1; en = 1'b1; up_dn = 1'b1; mode = 1'b0; start = 1'b0; load = 1'b0;
    load_val = '0; mod_val = 10'd1023; presc_div = '0;
    #1;
    chk_state("reset", 0, 1'b0, 1'b0, 1'b0);
    check_eq("reset.co", 32'(co), 32'd0);
    cyc();
    chk_state("reset_hold", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Full 10-bit free-run: 1..1023, 0 (wrap), 1.
    for (int k = 1; k <= 1025; k++) begin
      cyc();
      check_eq("free.count", 32'(count), 32'(k % 1024));
      check_eq("free.wrap",  32'(wrap),  32'(k == 1024));
      check_eq("free.co",    32'(co),    32'((k % 1024) == 1023));
    end

    // Modulus 9, down, step every 3rd cycle.
    mod_val = 10'd9; up_dn = 1'b0; presc_div = 8'd2; load = 1'b1; load_val = 10'd0;
    cyc();
    chk_state("down_load", 0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    for (int n = 1; n <= 36; n++) begin
      cyc();
      s = n / 3;
      exp_c = (10 - (s % 10)) % 10;
      check_eq("down.count", 32'(count), 32'(exp_c));
      check_eq("down.wrap",  32'(wrap),  32'((n % 3 == 0) && (s % 10 == 1)));
      check_eq("down.co",    32'(co),    32'(exp_c == 0));
    end

    // One-shot up to 5.
    mode = 1'b1; up_dn = 1'b1; mod_val = 10'd5; presc_div = 8'd0; start = 1'b1;
    cyc();
    chk_state("os_start", 0, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk_state("os_run", i, 1'b0, 1'b1, 1'b0);
    end
    check_eq("os_run.co", 32'(co), 32'd1);
    cyc();
    chk_state("os_term", 5, 1'b1, 1'b0, 1'b1);
    cyc();
    chk_state("os_hold1", 5, 1'b0, 1'b0, 1'b1);
    cyc();
    chk_state("os_hold2", 5, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    cyc();
    chk_state("os_restart", 0, 1'b0, 1'b1, 1'b0);
    start = 1'b0;

    // Load beats start; state stays RUN.
    load = 1'b1; start = 1'b1; load_val = 10'd700; mod_val = 10'd500;
    cyc();
    chk_state("load_prio", 700, 1'b0, 1'b1, 1'b0);
    // Back to free-run: 700 > 500 folds to 0 with wrap, FSM to IDLE.
    load = 1'b0; start = 1'b0; mode = 1'b0;
    cyc();
    chk_state("load_fold", 0, 1'b1, 1'b0, 1'b0);

    // en gating with presc_div=3.
    mod_val = 10'd1023; presc_div = 8'd3; load = 1'b1; load_val = 10'd0;
    cyc();
    load = 1'b0;
    cyc();
    cyc();
    check_eq("gate_pre.count", 32'(count), 32'd0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_eq("gate_off.count", 32'(count), 32'd0);
    end
    en = 1'b1;
    cyc();
    check_eq("gate_resume.count", 32'(count), 32'd0);
    cyc();
    check_eq("gate_step.count", 32'(count), 32'd1);
    cyc();
    cyc();
    // Load mid-phase must restart the prescaler phase.
    load = 1'b1; load_val = 10'd10;
    cyc();
    load = 1'b0;
    check_eq("presc_clr.load", 32'(count), 32'd10);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("presc_clr.hold", 32'(count), 32'd10);
    end
    cyc();
    check_eq("presc_clr.step", 32'(count), 32'd11);

    // mod_val=0: count pinned at 0, wrap on every step (first step folds 11 down).
    mod_val = 10'd0; presc_div = 8'd0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_state("mod0", 0, 1'b1, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-RUN at count 3.
    mode = 1'b1; mod_val = 10'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    chk_state("pre_rst", 3, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 0, 1'b0, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_state("post_rst_idle", 0, 1'b0, 1'b0, 1'b0);
    end
    start = 1'b1;
    cyc();
    chk_state("post_rst_start", 0, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    cyc();
    chk_state("post_rst_run", 1, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
